// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Divide operations share the upper op bit.
    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

    // Signed operations are the ones with op[0] clear.
    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction applied to the unsigned 64-bit result.
// Sign flags arrive already zeroed for unsigned operations.
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  logic        i_is_div,
    input  logic        i_neg_res,
    input  logic [63:0] i_acc,
    input  logic        i_neg_rem,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] w_prod;

    // Negate the product or the quotient/remainder halves as required.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_hi   = i_acc[63:32];
        o_lo   = i_acc[31:0];
        w_prod = i_neg_res ? (~i_acc + 64'd1) : i_acc;
        if (i_is_div) begin
            o_lo = i_neg_res ? (~i_acc[31:0] + 32'd1) : i_acc[31:0];
            o_hi = i_neg_rem ? (~i_acc[63:32] + 32'd1) : i_acc[63:32];
        end else begin
            o_hi = w_prod[63:32];
            o_lo = w_prod[31:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        Reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        cancel,
    input  logic        write_hi,
    input  logic        write_lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e           r_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      r_acc;
    logic [31:0]      r_b;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    op_e         w_op;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_trial;
    logic [63:0] w_acc_next;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_op    = op_e'(op);
    assign w_a_neg = is_signed_op(w_op) & operand_a[31];
    assign w_b_neg = is_signed_op(w_op) & operand_b[31];
    assign w_a_mag = w_a_neg ? (~operand_a + 32'd1) : operand_a;
    assign w_b_mag = w_b_neg ? (~operand_b + 32'd1) : operand_b;

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
        w_div_trial = r_acc[63:31] - {1'b0, r_b};
        if (is_div(r_op)) begin
            w_acc_next = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                         : {w_div_trial[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[31:1]};
        end
    end

    muldiv_sign_fix u_sign_fix (
        .i_is_div  (is_div(r_op)),
        .i_neg_res (r_neg_res),
        .i_acc     (r_acc),
        .i_neg_rem (r_neg_rem),
        .o_hi      (w_fix_hi),
        .o_lo      (w_fix_lo)
    );

    // Control FSM with registered busy/done and the HI/LO result registers.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state   <= ST_IDLE;
            r_op      <= OP_MULT;
            r_count   <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op  <= w_op;
                        r_dbz <= 1'b0;
                        r_busy <= 1'b1;
                        if (is_div(w_op) && (operand_b == 32'd0)) begin
                            // Divide by zero bypasses the datapath entirely.
                            r_hi    <= operand_a;
                            r_lo    <= 32'hFFFF_FFFF;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_acc     <= {32'd0, w_a_mag};
                            r_b       <= w_b_mag;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg & is_div(w_op);
                            r_count   <= CNT_W'(ITERATIONS - 1);
                            r_state   <= ST_CALC;
                        end
                    end else begin
                        if (write_hi) r_hi <= operand_a;
                        if (write_lo) r_lo <= operand_a;
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_count == '0) r_state <= ST_FIXUP;
                        else               r_count <= r_count - 1'b1;
                    end
                end
                ST_FIXUP: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clock;
    logic        Reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic        write_hi;
    logic        write_lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int n;
    int dones;

    muldiv_unit dut (
        .clock       (clock),
        .Reset       (Reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .cancel      (cancel),
        .write_hi    (write_hi),
        .write_lo    (write_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Present a start for one edge; edge count 1 is the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        step();
        start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    endtask

    // Wait (bounded) for done or for busy to drop; optionally re-pulse start or cancel.
    task automatic wait_done(input int rep_at, input int can_at, output int cnt);
        cnt = 1;
        while (cnt < 40 && !done && busy) begin
            if (cnt == rep_at) begin
                start = 1'b1; op = DIVU; operand_a = 32'd1; operand_b = 32'd0;
            end
            if (cnt == can_at) cancel = 1'b1;
            step();
            cnt++;
            start = 1'b0; cancel = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b0; start = 1'b0; op = MULT; operand_a = '0; operand_b = '0;
        cancel = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz",  32'(div_by_zero), 32'd0);
        check("rst_hi",   hi, 32'd0);
        check("rst_lo",   lo, 32'd0);
        @(negedge clock);
        Reset = 1'b1;
        step();

        // MTHI / MTLO in IDLE
        write_hi = 1'b1; operand_a = 32'hCAFE_BABE;
        step();
        write_hi = 1'b0;
        check("mthi_hi", hi, 32'hCAFE_BABE);
        write_lo = 1'b1; operand_a = 32'h0BAD_F00D;
        step();
        write_lo = 1'b0;
        check("mtlo_lo", lo, 32'h0BAD_F00D);
        check("mtlo_hi", hi, 32'hCAFE_BABE);

        // MULTU max x max, latency 34
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy", 32'(busy), 32'd1);
        wait_done(0, 0, n);
        check("multu_lat", 32'(n), 32'd34);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        step();
        check("multu_done_pulse", 32'(done), 32'd0);
        check("multu_idle", 32'(busy), 32'd0);

        // MULT -3 x 7 with an ignored start re-pulse at cycle 5
        launch(MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(5, 0, n);
        check("mult_lat", 32'(n), 32'd34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_dbz", 32'(div_by_zero), 32'd0);
        step();

        // Cancel at cycle 10: idle next cycle, no done, HI/LO untouched
        launch(MULTU, 32'd5, 32'd5);
        wait_done(0, 10, n);
        check("cancel_cycle", 32'(n), 32'd11);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_hi", hi, 32'hFFFF_FFFF);
        check("cancel_lo", lo, 32'hFFFF_FFEB);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) dones++;
            step();
        end
        check("cancel_no_done", 32'(dones), 32'd0);

        // Signed and unsigned divides
        launch(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 0, n);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        step();
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 0, n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
        check("div_ovf_dbz", 32'(div_by_zero), 32'd0);
        step();
        launch(DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, 0, n);
        check("div_7_m2_lo", lo, 32'hFFFF_FFFD);
        check("div_7_m2_hi", hi, 32'h0000_0001);
        step();
        launch(DIVU, 32'd100, 32'd7);
        wait_done(0, 0, n);
        check("divu_lat", 32'(n), 32'd34);
        check("divu_lo", lo, 32'h0000_000E);
        check("divu_hi", hi, 32'h0000_0002);
        step();

        // Divide by zero: done on the start edge's cycle, sticky flag
        launch(DIVU, 32'd100, 32'd0);
        wait_done(0, 0, n);
        check("dbz_lat", 32'(n), 32'd1);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        check("dbz_hi", hi, 32'h0000_0064);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        step();
        step();
        check("dbz_sticky", 32'(div_by_zero), 32'd1);
        check("dbz_idle", 32'(busy), 32'd0);

        // MTHI together with start: start wins, HI not written
        write_hi = 1'b1;
        launch(MULTU, 32'h1234_5678, 32'h0000_0100);
        check("mthi_start_hi", hi, 32'h0000_0064);
        check("start_clears_dbz", 32'(div_by_zero), 32'd0);
        wait_done(0, 0, n);
        check("mul_shift_hi", hi, 32'h0000_0012);
        check("mul_shift_lo", lo, 32'h3456_7800);
        step();

        // Asynchronous reset in the middle of CALC
        launch(MULTU, 32'hFFFF_FFFF, 32'd3);
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        Reset = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(negedge clock);
        Reset = 1'b1;
        step();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  in  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port: op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: operand_a  in  32  rs value from register file read_data_1.
REQ-006 SHALL have port: operand_b  in  32  rt value from register file read_data_2.
REQ-007 SHALL have port: cancel  in  1  abort the in-flight operation.
REQ-008 SHALL have port: write_hi  in  1  MTHI strobe, loads operand_a into hi.
REQ-009 SHALL have port: write_lo  in  1  MTLO strobe, loads operand_a into lo.
REQ-010 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port: done  out  1  one-cycle pulse when hi/lo hold a new result.
REQ-012 SHALL have port: div_by_zero  out  1  sticky until next accepted start; set by DIV/DIVU with operand_b=0.
REQ-013 SHALL have port: hi  out  32  product[63:32] or remainder.
REQ-014 SHALL have port: lo  out  32  product[31:0] or quotient.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-016 SHALL accept start in IDLE: latch op, the magnitudes of both operands and the result signs (signed ops only), clear div_by_zero, load iteration counter with 31, and enter CALC.
REQ-017 SHALL perform one radix-2 step per CALC cycle: shift-add for multiply, restoring shift-subtract for divide, on a 64-bit working register.
REQ-018 SHALL leave CALC for FIXUP when the counter reaches 0 (exactly 32 CALC cycles).
REQ-019 SHALL in FIXUP negate the product if the operand signs differ (MULT), negate the quotient if the signs differ, and give the remainder the sign of operand_a (DIV); SHALL then write hi/lo.
REQ-020 SHALL assert done for exactly the one DONE cycle, then return to IDLE; done is therefore high 34 cycles after the start edge.
REQ-021 SHALL, for DIV/DIVU with operand_b=0, skip CALC and go directly to DONE: hi=operand_a, lo=32'hFFFFFFFF, div_by_zero=1.
REQ-022 SHALL produce lo=32'h80000000, hi=0 for DIV 32'h80000000 / 32'hFFFFFFFF, with no trap.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL honour write_hi/write_lo only in IDLE; if start is high in the same cycle, start wins and the writes are dropped.
REQ-025 SHALL on cancel in CALC or FIXUP return to IDLE the next cycle, leave hi/lo unchanged, and not pulse done.
REQ-026 SHALL hold hi/lo stable except on FIXUP/DONE result writes and accepted MTHI/MTLO writes.

Reset
REQ-027 SHALL, while Reset=0 (including mid-operation), force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0 immediately, without waiting for a clock edge.

Structure
REQ-028 SHALL take op encodings, state encodings and ITERATIONS=32 from shared package muldiv_pkg.
REQ-029 SHALL isolate the sign-correction logic of REQ-019 in one combinational sub-module, muldiv_sign_fix.

Verification
REQ-030 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done exactly 34 cycles after start.
REQ-031 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-032 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-033 DIVU 100 / 0 -> done 1 cycle after start, div_by_zero=1, hi=32'h00000064, lo=32'hFFFFFFFF.
REQ-034 start re-pulsed at cycle 5 of a MULT is ignored (result unchanged); cancel at cycle 10 -> busy=0 next cycle, no done pulse, hi/lo keep prior values.
REQ-035 Reset driven low mid-CALC -> busy=0, hi=lo=0 before the next clock edge; MTHI with operand_a=32'h12345678 and start in the same IDLE cycle -> hi not written.
